// File: rtl/clock_divider_mc_if.sv
// Control/status bundle for the multi-channel clock divider.
// The master drives enables, ratios and sync; the slave returns the divided clocks, ticks and lock status.
interface clock_divider_mc_if #(
    parameter int NUM_CH = 2,
    parameter int W      = 8
);
    logic [NUM_CH-1:0]   i_clk_en;
    logic [NUM_CH*W-1:0] i_div_ratio;
    logic                i_sync;
    logic [NUM_CH-1:0]   o_div_clk;
    logic [NUM_CH-1:0]   o_div_tick;
    logic [NUM_CH-1:0]   o_locked;

    modport master (
        output i_clk_en, i_div_ratio, i_sync,
        input  o_div_clk, o_div_tick, o_locked
    );

    modport slave (
        input  i_clk_en, i_div_ratio, i_sync,
        output o_div_clk, o_div_tick, o_locked
    );
endinterface

// File: rtl/clock_divider_mc.sv
// Multi-channel integer clock divider: one divider lane per channel, with a shared reference clock and a shared phase-sync pulse.
// Ratio and enable are sampled only at period boundaries, so a running output never produces a runt pulse.
module clock_divider_ch #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] ratio,
    input  logic         sync,
    output logic         div_clk,
    output logic         tick,
    output logic         locked
);
    typedef enum logic {BYPASS = 1'b0, RUN = 1'b1} state_t;

    state_t       state;
    logic [W-1:0] r_a;
    logic [W-1:0] cnt;
    logic         div_q;

    logic         load;
    logic         wrap;
    logic [W-1:0] h;
    logic [W:0]   cnt_nx;

    assign load   = en && (ratio >= W'(2));
    assign wrap   = (cnt == r_a - W'(1));
    assign h      = r_a - (r_a >> 1);
    assign cnt_nx = {1'b0, cnt} + {{W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BYPASS;
            r_a   <= '0;
            cnt   <= '0;
            div_q <= 1'b0;
        end else begin
            case (state)
                BYPASS: begin
                    if (load) begin
                        state <= RUN;
                        r_a   <= ratio;
                        cnt   <= '0;
                        div_q <= 1'b1;
                    end
                end
                RUN: begin
                    // A sync pulse acts as an early wrap; when it coincides with a real wrap, only one reload happens.
                    if (wrap || sync) begin
                        if (load) begin
                            r_a   <= ratio;
                            cnt   <= '0;
                            div_q <= 1'b1;
                        end else begin
                            state <= BYPASS;
                            cnt   <= '0;
                            div_q <= 1'b0;
                        end
                    end else begin
                        cnt   <= cnt_nx[W-1:0];
                        div_q <= (cnt_nx < {1'b0, h});
                    end
                end
                default: state <= BYPASS;
            endcase
        end
    end

    // Only combinational clock path. A load happens while clk is high and div_q loads as 1, so the switch is glitch-free.
    assign div_clk = (state == BYPASS) ? clk : div_q;
    assign tick    = (state == RUN) && wrap;
    assign locked  = (state == RUN);
endmodule

module clock_divider_mc #(
    parameter int NUM_CH = 2,
    parameter int W      = 8
) (
    input  logic                 i_ref_clk,
    input  logic                 i_rst,
    clock_divider_mc_if.slave    bus
);
    logic [NUM_CH-1:0][W-1:0] ratio_lane;
    logic [NUM_CH-1:0]        div_clk;
    logic [NUM_CH-1:0]        tick;
    logic [NUM_CH-1:0]        locked;

    assign ratio_lane = bus.i_div_ratio;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clock_divider_ch #(.W(W)) u_ch (
            .clk     (i_ref_clk),
            .rst     (i_rst),
            .en      (bus.i_clk_en[c]),
            .ratio   (ratio_lane[c]),
            .sync    (bus.i_sync),
            .div_clk (div_clk[c]),
            .tick    (tick[c]),
            .locked  (locked[c])
        );
    end

    assign bus.o_div_clk  = div_clk;
    assign bus.o_div_tick = tick;
    assign bus.o_locked   = locked;
endmodule

// File: tb/tb_clock_divider_mc.sv
// Bench for clock_divider_mc: directed scenarios followed by random enable/ratio/sync/reset traffic.
// Every output is checked against a period-position reference model kept here.
module tb_clock_divider_mc;
    localparam int NUM_CH = 2;
    localparam int W      = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NUM_CH-1:0]   en = '0;
    logic [NUM_CH*W-1:0] ratio = '0;
    logic                sync = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    bit m_run [NUM_CH];
    int m_r   [NUM_CH];
    int m_p   [NUM_CH];

    always #5 clk = ~clk;

    clock_divider_mc_if #(.NUM_CH(NUM_CH), .W(W)) bus ();

    assign bus.i_clk_en    = en;
    assign bus.i_div_ratio = ratio;
    assign bus.i_sync      = sync;

    clock_divider_mc #(.NUM_CH(NUM_CH), .W(W)) dut (
        .i_ref_clk (clk),
        .i_rst     (rst),
        .bus       (bus)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Each channel is described by (running?, ratio in use, position within the current period).
    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            int  rq;
            bit  ld;
            rq = int'(ratio[c*W +: W]);
            ld = en[c] && (rq >= 2);
            if (rst) begin
                m_run[c] = 1'b0; m_r[c] = 0; m_p[c] = 0;
            end else if (!m_run[c]) begin
                if (ld) begin m_run[c] = 1'b1; m_r[c] = rq; m_p[c] = 0; end
            end else if (m_p[c] == m_r[c] - 1 || sync) begin
                if (ld) begin m_r[c] = rq; m_p[c] = 0; end
                else m_run[c] = 1'b0;
            end else begin
                m_p[c]++;
            end
        end
    endtask

    function automatic logic exp_high(input int c);
        return logic'(m_p[c] < (m_r[c] + 1) / 2);
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("locked[%0d]", c), bus.o_locked[c], logic'(m_run[c]));
            check($sformatf("tick[%0d]", c), bus.o_div_tick[c], logic'(m_run[c] && m_p[c] == m_r[c] - 1));
            check($sformatf("div_hiphase[%0d]", c), bus.o_div_clk[c], m_run[c] ? exp_high(c) : 1'b1);
        end
        @(negedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("div_lophase[%0d]", c), bus.o_div_clk[c], m_run[c] ? exp_high(c) : 1'b0);
    endtask

    task automatic set_ch(input int c, input logic e, input int r);
        en[c] = e;
        ratio[c*W +: W] = W'(r);
    endtask

    task automatic wait_pos(input int c, input int p);
        int k = 0;
        while (!(m_run[c] && m_p[c] == p) && k < 50) begin
            cycle();
            k++;
        end
        vectors++;
        assert (k < 50) else begin
            miscompares++;
            $error("FAIL wait_ch%0d_pos%0d: observed timeout after %0d cycles expected position reached", c, p, k);
        end
    endtask

    initial begin
        int t;
        // Reset state
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();

        // ch0 ratio 4: 2 high / 2 low, one tick per 4 cycles
        set_ch(0, 1'b1, 4);
        t = 0;
        repeat (40) begin
            cycle();
            t += int'(bus.o_div_tick[0]);
        end
        check_int("ticks_ratio4_40cyc", t, 10);

        // ch1 ratio 5 then 2
        set_ch(1, 1'b1, 5);
        repeat (15) cycle();
        set_ch(1, 1'b1, 2);
        repeat (10) cycle();

        // ratio change mid-period on ch0
        wait_pos(0, 1);
        set_ch(0, 1'b1, 6);
        repeat (20) cycle();

        // disable mid-period, then ratio 1 / 0 passthrough
        wait_pos(0, 1);
        set_ch(0, 1'b0, 6);
        repeat (8) cycle();
        set_ch(0, 1'b1, 1);
        repeat (4) cycle();
        set_ch(0, 1'b1, 0);
        repeat (4) cycle();

        // two channels one cycle apart, then sync
        set_ch(1, 1'b0, 4);
        repeat (6) cycle();
        set_ch(0, 1'b1, 4);
        cycle();
        set_ch(1, 1'b1, 4);
        repeat (5) cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        repeat (12) cycle();

        // reset mid-period with a simultaneous sync
        wait_pos(0, 2);
        rst  = 1'b1;
        sync = 1'b1;
        cycle();
        rst  = 1'b0;
        sync = 1'b0;
        repeat (6) cycle();

        // random traffic
        repeat (1500) begin
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 7) == 0)
                    set_ch(c, logic'($urandom_range(0, 5) != 0),
                           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 7)));
            sync = ($urandom_range(0, 24) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst  = 1'b0;
        sync = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
